// File: rtl/capture_seq_ctrl.sv
// Capture sequencer between the FIR output and the capture BRAM: start-edge detect,
// write enable/address generation, done/full status and abort. Optional: CAPTURE_DECIM_EN.
module capture_seq_ctrl #(
  parameter int NB_ADDR  = 11,
  parameter int DEPTH    = 2048,
  parameter int NB_DECIM = 4
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic                i_sample_valid,
  input  logic [NB_DECIM-1:0] i_decim,
  output logic                o_write_enable,
  output logic [NB_ADDR-1:0]  o_write_addr,
  output logic                o_busy,
  output logic                o_full,
  output logic                o_done_pulse,
  output logic [NB_ADDR:0]    o_sample_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_DONE    = 2'b10
  } state_t;

  localparam logic [NB_ADDR-1:0] LAST_ADDR  = NB_ADDR'(DEPTH - 1);
  localparam logic [NB_ADDR:0]   FULL_COUNT = (NB_ADDR + 1)'(DEPTH);

  state_t               state_q;
  logic                 start_q;
  logic [NB_ADDR-1:0]   addr_q;
  logic [NB_ADDR:0]     count_q;
  logic                 done_pulse_q;

  logic                 start_edge;
  logic                 capture_start;
  logic                 decim_tick;
  logic                 write_en;
  logic                 last_write;
  logic [NB_ADDR-1:0]   addr_d;
  logic [NB_ADDR:0]     count_d;

  assign start_edge    = i_start & ~start_q;
  // Abort wins over a start edge only when leaving DONE; IDLE always honours the edge.
  assign capture_start = start_edge &
                         ((state_q == ST_IDLE) | ((state_q == ST_DONE) & ~i_abort));

  // Combinational from registered state so the BRAM write lands with the valid sample.
  assign write_en   = (state_q == ST_CAPTURE) & i_sample_valid & decim_tick
                      & ~i_abort & ~i_reset;
  assign last_write = write_en & (addr_q == LAST_ADDR);
  assign addr_d     = (addr_q == LAST_ADDR) ? '0 : addr_q + NB_ADDR'(1);
  assign count_d    = (count_q == FULL_COUNT) ? count_q : count_q + (NB_ADDR + 1)'(1);

`ifdef CAPTURE_DECIM_EN
  logic [NB_DECIM-1:0] decim_q;
  logic [NB_DECIM-1:0] decim_cnt_q;
  logic                decim_wrap;

  assign decim_tick = (decim_cnt_q == '0);
  assign decim_wrap = (decim_q <= NB_DECIM'(1)) || (decim_cnt_q == decim_q - NB_DECIM'(1));

  always_ff @(posedge clock) begin
    if (i_reset) begin
      decim_q     <= '0;
      decim_cnt_q <= '0;
    end else if (capture_start) begin
      decim_q     <= i_decim;
      decim_cnt_q <= '0;
    end else if ((state_q == ST_CAPTURE) && i_sample_valid && !i_abort) begin
      decim_cnt_q <= decim_wrap ? '0 : decim_cnt_q + NB_DECIM'(1);
    end
  end
`else
  logic unused_decim;

  assign decim_tick   = 1'b1;
  assign unused_decim = ^i_decim;
`endif

  // NOTE: reset is synchronous and all state uses non-blocking assignments, so every
  // register sees the same pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b1;
      addr_q       <= '0;
      count_q      <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      start_q      <= i_start;
      done_pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (capture_start) begin
            state_q <= ST_CAPTURE;
            addr_q  <= '0;
            count_q <= '0;
          end
        end
        ST_CAPTURE: begin
          if (i_abort) begin
            state_q <= ST_IDLE;
          end else if (write_en) begin
            addr_q  <= addr_d;
            count_q <= count_d;
            if (last_write) begin
              state_q      <= ST_DONE;
              done_pulse_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (i_abort) begin
            state_q <= ST_IDLE;
          end else if (capture_start) begin
            state_q <= ST_CAPTURE;
            addr_q  <= '0;
            count_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_write_enable = write_en;
  assign o_write_addr   = addr_q;
  assign o_busy         = (state_q == ST_CAPTURE);
  assign o_full         = (state_q == ST_DONE);
  assign o_done_pulse   = done_pulse_q;
  assign o_sample_count = count_q;

endmodule

// File: tb/tb_capture_seq_ctrl.sv
// Scoreboard bench for capture_seq_ctrl: directed scenarios then randomized stimulus
// against a sample-counting reference model (follows CAPTURE_DECIM_EN if defined).
module tb_capture_seq_ctrl;

  localparam int NB_ADDR  = 3;
  localparam int DEPTH    = 8;
  localparam int NB_DECIM = 4;

  logic                clock = 1'b1;
  logic                i_reset;
  logic                i_start;
  logic                i_abort;
  logic                i_sample_valid;
  logic [NB_DECIM-1:0] i_decim;
  logic                o_write_enable;
  logic [NB_ADDR-1:0]  o_write_addr;
  logic                o_busy;
  logic                o_full;
  logic                o_done_pulse;
  logic [NB_ADDR:0]    o_sample_count;

  capture_seq_ctrl #(.NB_ADDR(NB_ADDR), .DEPTH(DEPTH), .NB_DECIM(NB_DECIM)) dut (
    .clock          (clock),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .i_sample_valid (i_sample_valid),
    .i_decim        (i_decim),
    .o_write_enable (o_write_enable),
    .o_write_addr   (o_write_addr),
    .o_busy         (o_busy),
    .o_full         (o_full),
    .o_done_pulse   (o_done_pulse),
    .o_sample_count (o_sample_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit rst;
    bit we;
    int addr;
    bit busy;
    bit full;
    bit pulse;
    int count;
  } exp_t;

  exp_t st_q[$];
  int   wr_q[$];
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e;

  // Reference model: capture phase plus sample tallies.
  int m_phase;        // 0 idle, 1 capturing, 2 full
  int m_written;
  int m_valid_seen;
  int m_ratio;
  bit m_prev_start;
  bit m_just_full;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (o_write_enable === 1'b1) begin
      if (wr_q.size() == 0) check("unexpected_write", int'(o_write_enable), 0);
      else check("write_addr", int'(o_write_addr), wr_q.pop_front());
    end
    if (st_q.size() > 0) begin
      mon_e = st_q.pop_front();
      check("write_enable", int'(o_write_enable), int'(mon_e.we));
      if (!mon_e.rst) begin
        check("busy", int'(o_busy), int'(mon_e.busy));
        check("full", int'(o_full), int'(mon_e.full));
        check("done_pulse", int'(o_done_pulse), int'(mon_e.pulse));
        check("sample_count", int'(o_sample_count), mon_e.count);
        check("addr", int'(o_write_addr), mon_e.addr);
      end
    end
  end

  function automatic bit sample_selected();
`ifdef CAPTURE_DECIM_EN
    int eff;
    eff = (m_ratio <= 1) ? 1 : m_ratio;
    return (m_valid_seen % eff) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_phase      = 0;
    m_written    = 0;
    m_valid_seen = 0;
    m_ratio      = 0;
    m_prev_start = 1'b1;
    m_just_full  = 1'b0;
  endtask

  task automatic begin_capture(input int decim);
    m_phase      = 1;
    m_written    = 0;
    m_valid_seen = 0;
    m_ratio      = decim;
  endtask

  // One clock cycle: drive inputs, predict outputs, advance the model.
  task automatic step(input bit rst, input bit start, input bit abort,
                      input bit valid, input int decim);
    exp_t e;
    bit   rose;
    i_reset        = rst;
    i_start        = start;
    i_abort        = abort;
    i_sample_valid = valid;
    i_decim        = NB_DECIM'(decim);
    e.rst   = rst;
    e.we    = !rst && m_phase == 1 && valid && !abort && sample_selected();
    e.addr  = m_written % DEPTH;
    e.busy  = (m_phase == 1);
    e.full  = (m_phase == 2);
    e.pulse = m_just_full;
    e.count = m_written;
    st_q.push_back(e);
    if (e.we) wr_q.push_back(m_written % DEPTH);
    if (rst) begin
      model_reset();
    end else begin
      rose        = start && !m_prev_start;
      m_just_full = 1'b0;
      if (m_phase == 0) begin
        if (rose) begin_capture(decim);
      end else if (m_phase == 1) begin
        if (abort) m_phase = 0;
        else begin
          if (valid) m_valid_seen++;
          if (e.we) m_written++;
          if (m_written == DEPTH) begin
            m_phase     = 2;
            m_just_full = 1'b1;
          end
        end
      end else begin
        if (abort) m_phase = 0;
        else if (rose) begin_capture(decim);
      end
      m_prev_start = start;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n, input bit start, input bit abort,
                     input bit valid, input int decim);
    for (int i = 0; i < n; i++) step(1'b0, start, abort, valid, decim);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rs, st, ab, va;
    int dc;
    model_reset();
    // Start held high through reset and afterwards must not trigger a capture.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 0);
    run(20, 1'b1, 1'b0, 1'b1, 0);

    // Continuous capture of DEPTH samples.
    run(2, 1'b0, 1'b0, 1'b1, 0);
    run(12, 1'b1, 1'b0, 1'b1, 0);

    // Start edge in DONE restarts; start edge mid-capture is ignored.
    run(1, 1'b0, 1'b0, 1'b1, 0);
    run(3, 1'b1, 1'b0, 1'b1, 0);
    run(1, 1'b0, 1'b0, 1'b1, 0);
    run(8, 1'b1, 1'b0, 1'b1, 0);

    // Valid toggling: writes only on valid cycles.
    run(2, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, (i % 2) == 1, 0);

    // Abort on the fourth valid sample.
    run(1, 1'b0, 1'b0, 1'b0, 0);
    run(1, 1'b1, 1'b0, 1'b0, 0);
    run(3, 1'b1, 1'b0, 1'b1, 0);
    run(1, 1'b1, 1'b1, 1'b1, 0);
    run(3, 1'b1, 1'b0, 1'b1, 0);

    // Decimation ratio 3 (every sample without the feature); abort+start in DONE.
    run(1, 1'b0, 1'b0, 1'b1, 3);
    run(30, 1'b1, 1'b0, 1'b1, 3);
    run(1, 1'b0, 1'b0, 1'b1, 3);
    run(1, 1'b1, 1'b1, 1'b1, 3);
    run(2, 1'b1, 1'b0, 1'b1, 3);

    // Reset in the middle of a capture.
    run(1, 1'b0, 1'b0, 1'b1, 0);
    run(3, 1'b1, 1'b0, 1'b1, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 0);
    run(3, 1'b1, 1'b0, 1'b1, 0);

    // Randomized traffic.
    st = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      rs = ($urandom_range(0, 250) == 0);
      if ($urandom_range(0, 12) == 0) st = ~st;
      ab = ($urandom_range(0, 45) == 0);
      va = ($urandom_range(0, 3) != 0);
      dc = $urandom_range(0, 5);
      step(rs, st, ab, va, dc);
    end

    @(negedge clock);
    check("drain_status_queue", st_q.size(), 0);
    check("drain_write_queue", wr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/capture_seq_ctrl.md
Name: capture_seq_ctrl

Overview:
Sequencer for the FIR-to-BRAM logging path. It detects a start request and generates the BRAM write-enable and write address for one capture of DEPTH FIR samples. It raises a full/done indication and supports abort. It replaces the free-running write counter plus FSM pair that sits between the filter output and the capture BRAM.

Parameters:
NB_ADDR, 11, width of BRAM write address
DEPTH, 2048, samples per capture; 1 <= DEPTH <= 2**NB_ADDR
NB_DECIM, 4, width of decimation ratio input (used only with CAPTURE_DECIM_EN)

Ports:
clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_start  in  1  start request, level (switch); rising edge detected internally
i_abort  in  1  abort current capture, level, sampled each cycle
i_sample_valid  in  1  FIR output valid strobe; tie 1 for continuous sampling
i_decim  in  NB_DECIM  decimation ratio (ignored without macro)
o_write_enable  out  1  BRAM write enable
o_write_addr  out  NB_ADDR  BRAM write address
o_busy  out  1  high while in CAPTURE
o_full  out  1  capture complete (LED); high in DONE
o_done_pulse  out  1  one-cycle pulse on entering DONE
o_sample_count  out  NB_ADDR+1  samples written in current/last capture

Behaviour:
- Reset: state IDLE, addr 0, count 0, o_busy/o_full/o_done_pulse/o_write_enable 0. The start-edge history register resets to 1, so i_start held high through reset does not start a capture.
- Start edge: start_edge = i_start & ~start_q. start_q is registered every cycle.
- States: IDLE(2'b00), CAPTURE(2'b01), DONE(2'b10). 2'b11 is illegal and recovers to IDLE on the next cycle.
- IDLE:
  - start_edge -> CAPTURE next cycle.
  - On that edge: addr <= 0, count <= 0, decimation counter <= 0, i_decim latched.
- CAPTURE:
  - o_write_enable = i_sample_valid & decim_tick & ~i_abort. This is combinational from registered state, so the write occurs in the same cycle as the valid sample (0 latency).
  - o_write_addr = current addr register. On each write, addr <= addr+1 and count <= count+1.
  - A write at addr == DEPTH-1 -> DONE next cycle. addr wraps to 0; count holds DEPTH.
  - i_abort -> IDLE next cycle. There is no write in the abort cycle (abort has priority), and count retains the samples already written.
  - start_edge in CAPTURE is ignored.
- DONE:
  - o_full = 1; o_done_pulse = 1 in the first DONE cycle only.
  - start_edge -> CAPTURE with addr/count cleared; o_full drops the next cycle.
  - i_abort -> IDLE, o_full 0.
  - Abort beats start when both occur in the same cycle.
- o_busy = (state == CAPTURE); o_full = (state == DONE). Both are registered-state decodes.
- o_sample_count saturates at DEPTH and never wraps.
- Reset mid-capture: immediate return to reset values. No write occurs in the reset cycle.

Optional Feature:
CAPTURE_DECIM_EN
- Defined:
  - A decimation counter (NB_DECIM bits) advances on each i_sample_valid in CAPTURE, and decim_tick = (counter == 0).
  - The counter wraps to 0 after reaching latched_decim-1.
  - latched_decim of 0 or 1 means every valid sample is written.
  - i_decim changes during a capture have no effect.
- Undefined: decim_tick = 1, i_decim is unused, and no decimation counter is synthesized.

Test Plan:
1. Assert i_reset with i_start=1, then release with i_start held 1 -> state stays IDLE, o_write_enable=0, o_full=0, count=0 for 20 cycles.
2. DEPTH=8, i_sample_valid=1, rising edge on i_start -> 8 consecutive writes at addr 0..7. o_done_pulse high one cycle after the addr-7 write; o_full=1, o_busy=0, count=8.
3. DEPTH=8, i_sample_valid toggling 1/0 -> writes only on valid cycles, addr steps by 1 per write. Done after 16 cycles of capture.
4. Abort asserted in the same cycle as the 4th valid sample -> only addr 0..2 written, no write that cycle. IDLE next cycle, count=3, o_full=0.
5. Start edge mid-capture -> ignored, capture completes normally. Start edge in DONE -> o_full clears next cycle, writes restart at addr 0.
6. With CAPTURE_DECIM_EN, i_decim=3, i_sample_valid=1 -> writes on valid samples 0,3,6,…, DEPTH writes total. Without the macro, the same stimulus writes every sample.
